// File: rtl/hanoi_move_sched.sv
// hanoi_move_sched: sequences a full Towers of Hanoi solution for NDISK disks
// (peg 0 -> peg 2), presenting one move per valid/ready handshake.
// A per-disk peg table is kept so every move is derived from the live state.
// Optional build macro HANOI_CHECK_EN adds a move-legality checker driving
// 'illegal'; without it 'illegal' is tied low.
module hanoi_move_sched #(
  parameter int NDISK = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  output logic       mv_valid,
  input  logic       mv_ready,
  output logic [2:0] mv_disk,
  output logic [1:0] mv_from,
  output logic [1:0] mv_to,
  output logic [7:0] mv_num,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  localparam int         LAST_I = (1 << NDISK) - 1;
  localparam logic [7:0] LAST   = LAST_I[7:0];
  // Top-of-peg value for an empty peg: larger than every real disk index.
  localparam logic [3:0] EMPTY  = 4'(NDISK);

  typedef enum logic [1:0] {IDLE, COMPUTE, PRESENT, DONE} state_t;

  state_t                 state;
  logic [NDISK-1:0][1:0]  pos;
  logic [7:0]             cnt;
  logic [3:0]             top [3];
  logic [1:0]             p0;
  logic [1:0]             oth_a;
  logic [1:0]             oth_b;
  logic [2:0]             nxt_disk;
  logic [1:0]             nxt_from;
  logic [1:0]             nxt_to;

  assign mv_valid = (state == PRESENT);
  assign busy     = (state == COMPUTE) || (state == PRESENT);
  assign done     = (state == DONE);

  // Top disk of each peg: the lowest-index disk sitting on it.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      top[p] = EMPTY;
      for (int d = NDISK - 1; d >= 0; d--) begin
        if (pos[d] == 2'(p)) top[p] = 4'(d);
      end
    end
  end

  // Next legal move: odd counts cycle the smallest disk, even counts make the
  // single legal move between the two pegs not holding disk 0.
  always_comb begin
    p0 = pos[0];
    case (p0)
      2'd0:    begin oth_a = 2'd1; oth_b = 2'd2; end
      2'd1:    begin oth_a = 2'd0; oth_b = 2'd2; end
      default: begin oth_a = 2'd0; oth_b = 2'd1; end
    endcase
    nxt_disk = 3'd0;
    nxt_from = p0;
    nxt_to   = p0;
    if (cnt[0]) begin
      if (NDISK % 2 == 0) nxt_to = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
      else                nxt_to = (p0 == 2'd0) ? 2'd2 : p0 - 2'd1;
    end else if (top[oth_a] < top[oth_b]) begin
      nxt_disk = top[oth_a][2:0];
      nxt_from = oth_a;
      nxt_to   = oth_b;
    end else begin
      nxt_disk = top[oth_b][2:0];
      nxt_from = oth_b;
      nxt_to   = oth_a;
    end
  end

`ifdef HANOI_CHECK_EN
  logic illegal_r;
  logic on_from;
  logic all_on2;
  logic chk_bad;

  // Legality of the presented move against the table, and final placement.
  always_comb begin
    on_from = 1'b0;
    all_on2 = 1'b1;
    for (int d = 0; d < NDISK; d++) begin
      if (3'(d) == mv_disk && pos[d] == mv_from) on_from = 1'b1;
      if (pos[d] != 2'd2) all_on2 = 1'b0;
    end
    chk_bad = !on_from
           || (top[mv_from] != {1'b0, mv_disk})
           || ({1'b0, mv_disk} >= top[mv_to]);
  end

  assign illegal = illegal_r;
`else
  assign illegal = 1'b0;
`endif

  // Sequencer: state, position table, move counter and registered move fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      pos     <= '0;
      cnt     <= '0;
      mv_disk <= '0;
      mv_from <= '0;
      mv_to   <= '0;
      mv_num  <= '0;
`ifdef HANOI_CHECK_EN
      illegal_r <= 1'b0;
`endif
    end else if (abort) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= COMPUTE;
            pos   <= '0;
            cnt   <= 8'd1;
`ifdef HANOI_CHECK_EN
            illegal_r <= 1'b0;
          end else if (state == DONE && !all_on2) begin
            illegal_r <= 1'b1;
`endif
          end
        end
        COMPUTE: begin
          mv_disk <= nxt_disk;
          mv_from <= nxt_from;
          mv_to   <= nxt_to;
          mv_num  <= cnt;
          state   <= PRESENT;
        end
        PRESENT: begin
          if (mv_ready) begin
            for (int d = 0; d < NDISK; d++) begin
              if (3'(d) == mv_disk) pos[d] <= mv_to;
            end
`ifdef HANOI_CHECK_EN
            if (chk_bad) illegal_r <= 1'b1;
`endif
            if (cnt == LAST) begin
              state <= DONE;
            end else begin
              cnt   <= cnt + 8'd1;
              state <= COMPUTE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hanoi_move_sched.sv
// Testbench for hanoi_move_sched: four instances (NDISK 3, 2, 5, 4), one active
// at a time. Expected moves go into a scoreboard queue; a monitor pops and
// compares on every handshake of the selected instance.
module tb_hanoi_move_sched;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [3:0]      start_s, abort_s, ready_s;
  wire  [3:0]      valid_s, busy_s, done_s, ill_s;
  wire  [3:0][2:0] disk_s;
  wire  [3:0][1:0] from_s, to_s;
  wire  [3:0][7:0] num_s;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : gi
      hanoi_move_sched #(.NDISK(g == 0 ? 3 : g == 1 ? 2 : g == 2 ? 5 : 4)) u_dut (
        .clk(clk), .reset(reset), .start(start_s[g]), .abort(abort_s[g]),
        .mv_valid(valid_s[g]), .mv_ready(ready_s[g]), .mv_disk(disk_s[g]),
        .mv_from(from_s[g]), .mv_to(to_s[g]), .mv_num(num_s[g]),
        .busy(busy_s[g]), .done(done_s[g]), .illegal(ill_s[g]));
    end
  endgenerate

  typedef struct {int disk; int from; int to; int num;} mv_t;
  mv_t sb[$];
  mv_t e;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  sel     = 0;

  int t3 [7][3] = '{'{0,0,2}, '{1,0,1}, '{0,2,1}, '{2,0,2}, '{0,1,0}, '{1,1,2}, '{0,0,2}};
  int t2 [3][3] = '{'{0,0,1}, '{1,0,2}, '{0,1,2}};

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Independent closed-form model of move m for n disks.
  function automatic mv_t gen(int n, int m);
    mv_t r;
    int f, t;
    r.disk = 0;
    while (((m >> r.disk) & 1) == 0) r.disk++;
    f = (m & (m - 1)) % 3;
    t = ((m | (m - 1)) + 1) % 3;
    if (n % 2 == 0) begin
      f = (f == 0) ? 0 : 3 - f;
      t = (t == 0) ? 0 : 3 - t;
    end
    r.from = f; r.to = t; r.num = m;
    return r;
  endfunction

  task automatic push_gen(int n, int first, int last);
    for (int m = first; m <= last; m++) sb.push_back(gen(n, m));
  endtask

  task automatic push_tbl(int which);
    mv_t r;
    if (which == 3) begin
      for (int i = 0; i < 7; i++) begin
        r.disk = t3[i][0]; r.from = t3[i][1]; r.to = t3[i][2]; r.num = i + 1;
        sb.push_back(r);
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r.disk = t2[i][0]; r.from = t2[i][1]; r.to = t2[i][2]; r.num = i + 1;
        sb.push_back(r);
      end
    end
  endtask

  // Scoreboard monitor: a handshake is seen at the falling edge before it commits.
  always @(negedge clk) begin
    if (!reset && valid_s[sel] && ready_s[sel]) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_move: got num %0d expected none", num_s[sel]);
      end else begin
        e = sb.pop_front();
        chk($sformatf("i%0d_move%0d_disk", sel, e.num), int'(disk_s[sel]), e.disk);
        chk($sformatf("i%0d_move%0d_from", sel, e.num), int'(from_s[sel]), e.from);
        chk($sformatf("i%0d_move%0d_to",   sel, e.num), int'(to_s[sel]),   e.to);
        chk($sformatf("i%0d_move%0d_num",  sel, e.num), int'(num_s[sel]),  e.num);
      end
    end
  end

  task automatic do_start();
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    start_s[sel] = 1'b0;
    chk("lat_compute_valid", int'(valid_s[sel]), 0);
    chk("lat_compute_busy", int'(busy_s[sel]), 1);
    @(posedge clk); #1;
    chk("lat_present_valid", int'(valid_s[sel]), 1);
  endtask

  task automatic wait_valid(string name);
    int c = 0;
    while (!valid_s[sel] && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    chk(name, int'(valid_s[sel]), 1);
  endtask

  task automatic step(int count);
    for (int i = 0; i < count; i++) begin
      wait_valid("step_wait_valid");
      ready_s[sel] = 1'b1;
      @(posedge clk); #1;
      ready_s[sel] = 1'b0;
    end
  endtask

  task automatic run_done(int budget);
    int c = 0;
    ready_s[sel] = 1'b1;
    while (!done_s[sel] && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    ready_s[sel] = 1'b0;
    chk("run_done", int'(done_s[sel]), 1);
    chk("run_done_busy", int'(busy_s[sel]), 0);
    chk("run_done_illegal", int'(ill_s[sel]), 0);
    chk("run_done_sb_empty", sb.size(), 0);
  endtask

  task automatic pulse_abort();
    abort_s[sel] = 1'b1;
    @(posedge clk); #1;
    abort_s[sel] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mv_t x;
    reset   = 1'b1;
    start_s = '0;
    abort_s = '0;
    ready_s = '0;
    #22;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid", int'(valid_s[i]), 0);
      chk("rst_busy", int'(busy_s[i]), 0);
      chk("rst_done", int'(done_s[i]), 0);
      chk("rst_num", int'(num_s[i]), 0);
      chk("rst_illegal", int'(ill_s[i]), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // NDISK=3 full run, ready held high
    sel = 0;
    push_tbl(3);
    ready_s[sel] = 1'b1;
    do_start();
    run_done(100);

    // NDISK=2 full run
    sel = 1;
    push_tbl(2);
    ready_s[sel] = 1'b1;
    do_start();
    run_done(100);

    // NDISK=3 from DONE, backpressure at move 4
    sel = 0;
    push_tbl(3);
    do_start();
    step(3);
    wait_valid("bp_wait_move4");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", int'(valid_s[sel]), 1);
      chk("bp_disk", int'(disk_s[sel]), 2);
      chk("bp_from", int'(from_s[sel]), 0);
      chk("bp_to", int'(to_s[sel]), 2);
      chk("bp_num", int'(num_s[sel]), 4);
      @(posedge clk); #1;
    end
    run_done(100);

    // NDISK=5 full run, then restart
    sel = 2;
    push_gen(5, 1, 31);
    ready_s[sel] = 1'b1;
    do_start();
    run_done(200);
    x.disk = 0; x.from = 0; x.to = 2; x.num = 1;
    sb.push_back(x);
    do_start();
    step(1);
    pulse_abort();
    chk("n5_restart_sb_empty", sb.size(), 0);
    chk("n5_abort_busy", int'(busy_s[sel]), 0);

    // NDISK=4 abort at move 6
    sel = 3;
    push_gen(4, 1, 5);
    do_start();
    step(5);
    wait_valid("ab_wait_move6");
    chk("ab_num", int'(num_s[sel]), 6);
    chk("ab_disk", int'(disk_s[sel]), 1);
    chk("ab_from", int'(from_s[sel]), 2);
    chk("ab_to", int'(to_s[sel]), 1);
    pulse_abort();
    chk("ab_valid", int'(valid_s[sel]), 0);
    chk("ab_busy", int'(busy_s[sel]), 0);
    chk("ab_done", int'(done_s[sel]), 0);
    @(posedge clk); #1;
    chk("ab_idle_valid", int'(valid_s[sel]), 0);
    x.disk = 0; x.from = 0; x.to = 1; x.num = 1;
    sb.push_back(x);
    push_gen(4, 2, 15);
    ready_s[sel] = 1'b1;
    do_start();
    run_done(200);
    chk("n4_last_num", int'(num_s[sel]), 15);

    // Asynchronous reset while in COMPUTE
    start_s[sel] = 1'b1;
    @(posedge clk); #1;
    start_s[sel] = 1'b0;
    chk("rc_busy", int'(busy_s[sel]), 1);
    #2 reset = 1'b1;
    #1;
    chk("rc_valid", int'(valid_s[sel]), 0);
    chk("rc_disk", int'(disk_s[sel]), 0);
    chk("rc_from", int'(from_s[sel]), 0);
    chk("rc_to", int'(to_s[sel]), 0);
    chk("rc_num", int'(num_s[sel]), 0);
    chk("rc_busy_low", int'(busy_s[sel]), 0);
    chk("rc_done", int'(done_s[sel]), 0);
    chk("rc_illegal", int'(ill_s[sel]), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef HANOI_CHECK_EN
    // Corrupt the table under a presented move: the checker must flag it
    push_gen(4, 1, 3);
    do_start();
    step(2);
    wait_valid("ck_wait_move3");
    force gi[3].u_dut.pos = 8'h00;
    step(1);
    release gi[3].u_dut.pos;
    chk("ck_illegal_set", int'(ill_s[sel]), 1);
    pulse_abort();
    chk("ck_illegal_sticky", int'(ill_s[sel]), 1);
    do_start();
    chk("ck_illegal_cleared", int'(ill_s[sel]), 0);
    pulse_abort();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
